// File: rtl/pe_id_scan_loader_pkg.sv
// Shared types for the PE ID scan loader: FSM states, table selects,
// and helpers for the derived widths (NUM_PE, IDW).
package pe_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT_X = 3'd1,
        S_SHIFT_Y = 3'd2,
        S_LOAD_LN = 3'd3,
        S_DONE    = 3'd4
    } scan_state_e;

    localparam logic [2:0] TBL_IFMAP_X  = 3'd0;
    localparam logic [2:0] TBL_FILTER_X = 3'd1;
    localparam logic [2:0] TBL_IPSUM_X  = 3'd2;
    localparam logic [2:0] TBL_OPSUM_X  = 3'd3;
    localparam logic [2:0] TBL_IFMAP_Y  = 3'd4;
    localparam logic [2:0] TBL_FILTER_Y = 3'd5;
    localparam logic [2:0] TBL_IPSUM_Y  = 3'd6;
    localparam logic [2:0] TBL_OPSUM_Y  = 3'd7;

    function automatic int num_pe(input int rows, input int cols);
        return rows * cols;
    endfunction

    function automatic int idw(input int xb, input int yb);
        return (xb > yb) ? xb : yb;
    endfunction

endpackage

// File: rtl/pe_id_scan_loader_if.sv
// Table-write port (driven by master) and scan-chain outputs (driven by slave).
// slave = loader, master = software/testbench side.
interface pe_id_scan_loader_if
    import pe_scan_pkg::*;
#(
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8,
    parameter int XID_BITS    = 4,
    parameter int YID_BITS    = 3
);
    localparam int NUM_PE = num_pe(NUMS_PE_ROW, NUMS_PE_COL);
    localparam int IDX_W  = $clog2(NUM_PE);
    localparam int IDW    = idw(XID_BITS, YID_BITS);

    logic                   tbl_we;
    logic [2:0]             tbl_sel;
    logic [IDX_W-1:0]       tbl_addr;
    logic [IDW-1:0]         tbl_wdata;

    logic                   set_XID;
    logic [XID_BITS-1:0]    ifmap_XID_scan_in;
    logic [XID_BITS-1:0]    filter_XID_scan_in;
    logic [XID_BITS-1:0]    ipsum_XID_scan_in;
    logic [XID_BITS-1:0]    opsum_XID_scan_in;
    logic                   set_YID;
    logic [YID_BITS-1:0]    ifmap_YID_scan_in;
    logic [YID_BITS-1:0]    filter_YID_scan_in;
    logic [YID_BITS-1:0]    ipsum_YID_scan_in;
    logic [YID_BITS-1:0]    opsum_YID_scan_in;
    logic                   set_LN;
    logic [NUMS_PE_ROW-2:0] LN_config_in;

    modport slave (
        input  tbl_we, tbl_sel, tbl_addr, tbl_wdata,
        output set_XID, ifmap_XID_scan_in, filter_XID_scan_in,
        output ipsum_XID_scan_in, opsum_XID_scan_in,
        output set_YID, ifmap_YID_scan_in, filter_YID_scan_in,
        output ipsum_YID_scan_in, opsum_YID_scan_in,
        output set_LN, LN_config_in
    );

    modport master (
        output tbl_we, tbl_sel, tbl_addr, tbl_wdata,
        input  set_XID, ifmap_XID_scan_in, filter_XID_scan_in,
        input  ipsum_XID_scan_in, opsum_XID_scan_in,
        input  set_YID, ifmap_YID_scan_in, filter_YID_scan_in,
        input  ipsum_YID_scan_in, opsum_YID_scan_in,
        input  set_LN, LN_config_in
    );

endinterface

// File: rtl/pe_id_table.sv
// Four-channel DEPTH x W register file: one write port (channel+addr),
// four parallel reads at one address. Out-of-range addresses write nothing, read 0.
module pe_id_table #(
    parameter int DEPTH = 48,
    parameter int W     = 4,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [1:0]    wch,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata [4]
);
    localparam int LAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEP = (AW+1)'(DEPTH);

    logic [W-1:0]   r_mem [4][DEPTH];
    logic [LAW-1:0] w_wa;
    logic [LAW-1:0] w_ra;
    logic           w_wok;
    logic           w_rok;

    assign w_wa  = waddr[LAW-1:0];
    assign w_ra  = raddr[LAW-1:0];
    assign w_wok = we && ({1'b0, waddr} < DEP);
    assign w_rok = {1'b0, raddr} < DEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < DEPTH; i++)
                    r_mem[c][i] <= '0;
        end else if (w_wok) begin
            r_mem[wch][w_wa] <= wdata;
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++)
            rdata[c] = w_rok ? r_mem[c][w_ra] : '0;
    end

endmodule

// File: rtl/pe_id_scan_loader.sv
// Shifts XID/YID tables into the PE array scan chains, loads LN, pulses done.
// Ports: clk, rst (async active-low), start, cfg_hold, busy, done, ln_cfg,
// bus (tables in / scan out). ID_SCAN_CHECKSUM_EN adds scan_checksum[15:0].
module pe_id_scan_loader
    import pe_scan_pkg::*;
#(
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8,
    parameter int XID_BITS    = 4,
    parameter int YID_BITS    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cfg_hold,
    output logic                   busy,
    output logic                   done,
    input  logic [NUMS_PE_ROW-2:0] ln_cfg,
`ifdef ID_SCAN_CHECKSUM_EN
    output logic [15:0]            scan_checksum,
`endif
    pe_id_scan_loader_if.slave     bus
);
    localparam int NUM_PE = num_pe(NUMS_PE_ROW, NUMS_PE_COL);
    localparam int IDX_W  = $clog2(NUM_PE);
    localparam int IDW    = idw(XID_BITS, YID_BITS);
    localparam logic [IDX_W-1:0] X_LAST = IDX_W'(NUM_PE - 1);
    localparam logic [IDX_W-1:0] Y_LAST = IDX_W'(NUMS_PE_ROW - 1);

    scan_state_e            r_state;
    logic [IDX_W-1:0]       r_cnt;
    logic [NUMS_PE_ROW-2:0] r_ln;
    logic [NUMS_PE_ROW-2:0] r_ln_o;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_set_x;
    logic                   r_set_y;
    logic                   r_set_ln;
    logic [XID_BITS-1:0]    r_x [4];
    logic [YID_BITS-1:0]    r_y [4];
    logic [XID_BITS-1:0]    w_xr [4];
    logic [YID_BITS-1:0]    w_yr [4];
    logic                   w_open;
    logic                   w_we_x;
    logic                   w_we_y;
    logic                   w_hold;
    logic [IDW-1:0]         w_wd;

    // the busy flag also covers the done cycle, so a start/write seen
    // alongside done is dropped too
    assign w_open = (r_state == S_IDLE) && !r_busy;
    assign w_we_x = bus.tbl_we && w_open && (bus.tbl_sel < TBL_IFMAP_Y);
    assign w_we_y = bus.tbl_we && w_open && (bus.tbl_sel >= TBL_IFMAP_Y);
    assign w_wd   = bus.tbl_wdata;
    assign w_hold = cfg_hold && (r_state inside {S_SHIFT_X, S_SHIFT_Y, S_LOAD_LN});

    pe_id_table #(.DEPTH(NUM_PE), .W(XID_BITS), .AW(IDX_W)) u_xtbl (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we_x),
        .wch   (bus.tbl_sel[1:0]),
        .waddr (bus.tbl_addr),
        .wdata (w_wd[XID_BITS-1:0]),
        .raddr (r_cnt),
        .rdata (w_xr)
    );

    pe_id_table #(.DEPTH(NUMS_PE_ROW), .W(YID_BITS), .AW(IDX_W)) u_ytbl (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we_y),
        .wch   (bus.tbl_sel[1:0]),
        .waddr (bus.tbl_addr),
        .wdata (w_wd[YID_BITS-1:0]),
        .raddr (r_cnt),
        .rdata (w_yr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ln     <= '0;
            r_ln_o   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_set_x  <= 1'b0;
            r_set_y  <= 1'b0;
            r_set_ln <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                r_x[c] <= '0;
                r_y[c] <= '0;
            end
        end else begin
            r_set_x  <= 1'b0;
            r_set_y  <= 1'b0;
            r_set_ln <= 1'b0;
            r_done   <= 1'b0;
            r_ln_o   <= '0;
            r_busy   <= (r_state != S_IDLE);
            if (!w_hold) begin
                for (int c = 0; c < 4; c++) begin
                    r_x[c] <= '0;
                    r_y[c] <= '0;
                end
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start && w_open) begin
                        r_state <= S_SHIFT_X;
                        r_cnt   <= X_LAST;
                        r_ln    <= ln_cfg;
                    end
                end
                S_SHIFT_X: begin
                    if (!cfg_hold) begin
                        r_set_x <= 1'b1;
                        r_x     <= w_xr;
                        if (r_cnt == '0) begin
                            r_state <= S_SHIFT_Y;
                            r_cnt   <= Y_LAST;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_SHIFT_Y: begin
                    if (!cfg_hold) begin
                        r_set_y <= 1'b1;
                        r_y     <= w_yr;
                        if (r_cnt == '0) r_state <= S_LOAD_LN;
                        else r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_LOAD_LN: begin
                    if (!cfg_hold) begin
                        r_set_ln <= 1'b1;
                        r_ln_o   <= r_ln;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ID_SCAN_CHECKSUM_EN
    logic [15:0] r_sum;
    logic [15:0] w_add;

    always_comb begin
        w_add = '0;
        for (int c = 0; c < 4; c++) begin
            if (r_state == S_SHIFT_X) w_add = w_add + 16'(w_xr[c]);
            else w_add = w_add + 16'(w_yr[c]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
        end else if (r_state == S_IDLE) begin
            if (start && w_open) r_sum <= '0;
        end else if (!cfg_hold &&
                     (r_state inside {S_SHIFT_X, S_SHIFT_Y})) begin
            r_sum <= r_sum + w_add;
        end
    end

    assign scan_checksum = r_sum;
`endif

    assign busy                   = r_busy;
    assign done                   = r_done;
    assign bus.set_XID            = r_set_x;
    assign bus.ifmap_XID_scan_in  = r_x[0];
    assign bus.filter_XID_scan_in = r_x[1];
    assign bus.ipsum_XID_scan_in  = r_x[2];
    assign bus.opsum_XID_scan_in  = r_x[3];
    assign bus.set_YID            = r_set_y;
    assign bus.ifmap_YID_scan_in  = r_y[0];
    assign bus.filter_YID_scan_in = r_y[1];
    assign bus.ipsum_YID_scan_in  = r_y[2];
    assign bus.opsum_YID_scan_in  = r_y[3];
    assign bus.set_LN             = r_set_ln;
    assign bus.LN_config_in       = r_ln_o;

endmodule
